// File: rtl/pkt_key_extract_if.sv
// Port-side bundle of pkt_key_extract: packet ingress, packet egress toward um,
// key handoff to the match engine, and the status counters.
interface pkt_key_extract_if;
   logic          pktin_data_wr;
   logic [133:0]  pktin_data;
   logic          pktin_data_valid_wr;
   logic          pktin_data_valid;
   logic          pktin_ready;
   logic          pktout_data_wr;
   logic [133:0]  pktout_data;
   logic          pktout_data_valid_wr;
   logic          pktout_data_valid;
   logic          pktout_ready;
   logic          key_wr;
   logic          key_valid;
   logic [511:0]  key;
   logic          key_ready;
   logic [31:0]   pkt_cnt;
   logic [15:0]   err_cnt;

   modport slave (
      input  pktin_data_wr, pktin_data, pktin_data_valid_wr, pktin_data_valid,
      input  pktout_ready, key_ready,
      output pktin_ready, pktout_data_wr, pktout_data, pktout_data_valid_wr,
      output pktout_data_valid, key_wr, key_valid, key, pkt_cnt, err_cnt
   );

   modport master (
      output pktin_data_wr, pktin_data, pktin_data_valid_wr, pktin_data_valid,
      output pktout_ready, key_ready,
      input  pktin_ready, pktout_data_wr, pktout_data, pktout_data_valid_wr,
      input  pktout_data_valid, key_wr, key_valid, key, pkt_cnt, err_cnt
   );
endinterface

// File: rtl/pkt_key_extract.sv
// Ingress stage ahead of um: buffers packets in a pass-through FIFO and builds a
// 512-bit lookup key from the first four beats of every packet.
module pkt_key_extract #(
   parameter int FIFO_AW   = 8,
   parameter int AF_MARGIN = 8,
   parameter int KEY_BEATS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   pkt_key_extract_if.slave bus
);

   localparam int                 DEPTH    = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   AF_LVL_C = (FIFO_AW + 1)'(DEPTH - AF_MARGIN);
   localparam logic [1:0]         LAST_IDX = 2'(KEY_BEATS - 1);
   localparam logic [1:0]         T_HEAD   = 2'b01;
   localparam logic [1:0]         T_TAIL   = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_COLLECT  = 2'd1,
      S_KEY_WAIT = 2'd2,
      S_BODY     = 2'd3
   } state_t;

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {15'd0, b};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

   state_t        state_r, state_nxt_s;
   state_t        wait_ret_r, wait_ret_nxt_s;
   logic [1:0]    beat_idx_r, beat_idx_nxt_s;
   logic [511:0]  key_acc_r, key_acc_nxt_s;
   logic [511:0]  key_r;
   logic [511:0]  merged_s;
   logic [511:0]  pend_key_s;
   logic          key_pend_s;
   logic          key_fire_s;
   logic          key_wr_r;
   logic          fifo_wr_s;
   logic          frame_err_s;
   logic          tail_acc_s;

   logic [1:0]    in_type_s;
   logic [127:0]  payload_s;
   logic          is_head_s;
   logic          is_tail_s;
   logic          accept_s;
   logic          valid_lat_r;
   logic          flag_s;

   logic [134:0]  mem_r [DEPTH];
   logic [FIFO_AW:0] wr_ptr_r, rd_ptr_r;
   logic [FIFO_AW:0] occ_s, occ_nxt_s;
   logic          full_s, empty_s;
   logic          push_s, pop_s;
   logic          overflow_s;
   logic [134:0]  rd_data_s;

   logic          pktin_ready_r;
   logic          pktout_wr_r;
   logic [133:0]  pktout_data_r;
   logic          pktout_vwr_r;
   logic          pktout_v_r;
   logic [31:0]   pkt_cnt_r;
   logic [15:0]   err_cnt_r;
   logic [1:0]    err_add_s;

   assign in_type_s  = bus.pktin_data[133:132];
   assign payload_s  = bus.pktin_data[127:0];
   assign is_head_s  = (in_type_s == T_HEAD);
   assign is_tail_s  = (in_type_s == T_TAIL);
   assign accept_s   = bus.pktin_data_wr && (state_r != S_KEY_WAIT);
   assign flag_s     = is_tail_s && (bus.pktin_data_valid_wr ? bus.pktin_data_valid : valid_lat_r);

   // Current key accumulator with the incoming beat dropped into its slot
   always_comb begin
      merged_s = key_acc_r;
      case (beat_idx_r)
         2'd1:    merged_s[383:256] = payload_s;
         2'd2:    merged_s[255:128] = payload_s;
         2'd3:    merged_s[127:0]   = payload_s;
         default: merged_s[511:384] = payload_s;
      endcase
   end

   // Framing state machine: next state, key accumulation and per-beat events
   always_comb begin
      state_nxt_s    = state_r;
      wait_ret_nxt_s = wait_ret_r;
      beat_idx_nxt_s = beat_idx_r;
      key_acc_nxt_s  = key_acc_r;
      pend_key_s     = key_acc_r;
      key_pend_s     = 1'b0;
      key_fire_s     = 1'b0;
      fifo_wr_s      = 1'b0;
      frame_err_s    = 1'b0;
      tail_acc_s     = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (accept_s && is_head_s) begin
               fifo_wr_s      = 1'b1;
               key_acc_nxt_s  = {payload_s, 384'd0};
               beat_idx_nxt_s = 2'd1;
               state_nxt_s    = S_COLLECT;
            end else if (accept_s) begin
               frame_err_s = 1'b1;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_COLLECT: begin
            if (accept_s && is_head_s) begin
               // missing tail: flush the partial key, then restart on this head
               fifo_wr_s      = 1'b1;
               frame_err_s    = 1'b1;
               key_pend_s     = 1'b1;
               pend_key_s     = key_acc_r;
               key_acc_nxt_s  = {payload_s, 384'd0};
               beat_idx_nxt_s = 2'd1;
               if (bus.key_ready) begin
                  key_fire_s  = 1'b1;
                  state_nxt_s = S_COLLECT;
               end else begin
                  wait_ret_nxt_s = S_COLLECT;
                  state_nxt_s    = S_KEY_WAIT;
               end
            end else if (accept_s) begin
               fifo_wr_s      = 1'b1;
               tail_acc_s     = is_tail_s;
               key_acc_nxt_s  = merged_s;
               beat_idx_nxt_s = beat_idx_r + 2'd1;
               if (is_tail_s || (beat_idx_r == LAST_IDX)) begin
                  key_pend_s = 1'b1;
                  pend_key_s = merged_s;
                  if (bus.key_ready) begin
                     key_fire_s  = 1'b1;
                     state_nxt_s = is_tail_s ? S_IDLE : S_BODY;
                  end else begin
                     wait_ret_nxt_s = is_tail_s ? S_IDLE : S_BODY;
                     state_nxt_s    = S_KEY_WAIT;
                  end
               end else begin
                  state_nxt_s = S_COLLECT;
               end
            end else begin
               state_nxt_s = S_COLLECT;
            end
         end
         S_KEY_WAIT: begin
            if (bus.key_ready) begin
               key_fire_s  = 1'b1;
               state_nxt_s = wait_ret_r;
            end else begin
               state_nxt_s = S_KEY_WAIT;
            end
         end
         S_BODY: begin
            if (accept_s && is_head_s) begin
               fifo_wr_s      = 1'b1;
               frame_err_s    = 1'b1;
               key_acc_nxt_s  = {payload_s, 384'd0};
               beat_idx_nxt_s = 2'd1;
               state_nxt_s    = S_COLLECT;
            end else if (accept_s) begin
               fifo_wr_s   = 1'b1;
               tail_acc_s  = is_tail_s;
               state_nxt_s = is_tail_s ? S_IDLE : S_BODY;
            end else begin
               state_nxt_s = S_BODY;
            end
         end
         default: begin
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   assign occ_s      = wr_ptr_r - rd_ptr_r;
   assign full_s     = occ_s[FIFO_AW];
   assign empty_s    = (occ_s == '0);
   assign push_s     = fifo_wr_s && !full_s;
   assign overflow_s = fifo_wr_s && full_s;
   assign pop_s      = !empty_s && bus.pktout_ready;
   assign occ_nxt_s  = occ_s + {{FIFO_AW{1'b0}}, push_s} - {{FIFO_AW{1'b0}}, pop_s};
   assign rd_data_s  = mem_r[rd_ptr_r[FIFO_AW-1:0]];
   assign err_add_s  = {1'b0, frame_err_s} + {1'b0, overflow_s};

   // FIFO storage; entries carry the valid flag above the 134-bit beat
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r[FIFO_AW-1:0]] <= {flag_s, bus.pktin_data};
      end
   end

   // FSM, key, pointer and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_IDLE;
         wait_ret_r  <= S_IDLE;
         beat_idx_r  <= 2'd0;
         key_acc_r   <= 512'd0;
         key_r       <= 512'd0;
         key_wr_r    <= 1'b0;
         valid_lat_r <= 1'b0;
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         pkt_cnt_r   <= 32'd0;
         err_cnt_r   <= 16'd0;
      end else begin
         state_r    <= state_nxt_s;
         wait_ret_r <= wait_ret_nxt_s;
         beat_idx_r <= beat_idx_nxt_s;
         key_acc_r  <= key_acc_nxt_s;
         key_wr_r   <= key_fire_s;
         if (key_pend_s) begin
            key_r <= pend_key_s;
         end
         if (bus.pktin_data_wr && bus.pktin_data_valid_wr) begin
            valid_lat_r <= bus.pktin_data_valid;
         end
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + {{FIFO_AW{1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{FIFO_AW{1'b0}}, 1'b1};
         end
         if (tail_acc_s) begin
            pkt_cnt_r <= pkt_cnt_r + 32'd1;
         end
         err_cnt_r <= sat_add16(err_cnt_r, err_add_s);
      end
   end

   // Registered egress beat and upstream flow control
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pktin_ready_r <= 1'b1;
         pktout_wr_r   <= 1'b0;
         pktout_data_r <= 134'd0;
         pktout_vwr_r  <= 1'b0;
         pktout_v_r    <= 1'b0;
      end else begin
         pktin_ready_r <= (occ_nxt_s < AF_LVL_C) && (state_nxt_s != S_KEY_WAIT);
         pktout_wr_r   <= pop_s;
         pktout_data_r <= pop_s ? rd_data_s[133:0] : 134'd0;
         pktout_vwr_r  <= pop_s && (rd_data_s[133:132] == T_TAIL);
         pktout_v_r    <= pop_s && (rd_data_s[133:132] == T_TAIL) && rd_data_s[134];
      end
   end

   assign bus.pktin_ready          = pktin_ready_r;
   assign bus.pktout_data_wr       = pktout_wr_r;
   assign bus.pktout_data          = pktout_data_r;
   assign bus.pktout_data_valid_wr = pktout_vwr_r;
   assign bus.pktout_data_valid    = pktout_v_r;
   assign bus.key_wr               = key_wr_r;
   assign bus.key_valid            = key_wr_r;
   assign bus.key                  = key_r;
   assign bus.pkt_cnt              = pkt_cnt_r;
   assign bus.err_cnt              = err_cnt_r;

endmodule

// File: tb/tb_pkt_key_extract.sv
// Directed bench for pkt_key_extract: framing, key emission, back-pressure,
// FIFO overflow and asynchronous reset, each with hand-computed expectations.
module tb_pkt_key_extract;

   localparam logic [1:0] HD = 2'b01;
   localparam logic [1:0] MD = 2'b11;
   localparam logic [1:0] TL = 2'b10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   exp_pkt = 0;
   int   exp_err = 0;

   pkt_key_extract_if bus();

   pkt_key_extract #(.FIFO_AW(8), .AF_MARGIN(8), .KEY_BEATS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [133:0] out_q[$];
   int           out_cyc_q[$];
   logic         out_vwr_q[$];
   logic         out_v_q[$];
   logic [511:0] key_q[$];
   int           key_cyc_q[$];

   // Collect egress beats and key strobes away from the active edge
   always @(negedge clk) begin
      if (rst_n && bus.pktout_data_wr) begin
         out_q.push_back(bus.pktout_data);
         out_cyc_q.push_back(cyc);
         out_vwr_q.push_back(bus.pktout_data_valid_wr);
         out_v_q.push_back(bus.pktout_data_valid);
      end
      if (rst_n && bus.key_wr && bus.key_valid) begin
         key_q.push_back(bus.key);
         key_cyc_q.push_back(cyc);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic clear_q();
      out_q.delete(); out_cyc_q.delete(); out_vwr_q.delete(); out_v_q.delete();
      key_q.delete(); key_cyc_q.delete();
   endtask

   task automatic drive_beat(input logic [1:0] typ, input logic [127:0] pl, input logic vwr,
                             input logic v, input bit force_wr, output int c);
      int k;
      k = 0;
      if (!force_wr) begin
         while (bus.pktin_ready !== 1'b1 && k < 200) begin
            @(posedge clk); #1; k++;
         end
         n_vec++;
         if (k >= 200) begin
            n_err++;
            $display("FAIL ready_wait: pktin_ready stayed %b, need 1", bus.pktin_ready);
         end
      end
      bus.pktin_data_wr       = 1'b1;
      bus.pktin_data          = {typ, 4'd0, pl};
      bus.pktin_data_valid_wr = vwr;
      bus.pktin_data_valid    = v;
      c = cyc;
      @(posedge clk); #1;
      bus.pktin_data_wr       = 1'b0;
      bus.pktin_data_valid_wr = 1'b0;
      bus.pktin_data_valid    = 1'b0;
      bus.pktin_data          = 134'd0;
   endtask

   task automatic wait_outs(input int n, input int budget);
      int k;
      k = 0;
      while (out_q.size() < n && k < budget) begin
         @(posedge clk); #1; k++;
      end
      repeat (4) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      bus.pktin_data_wr = 1'b0; bus.pktin_data = 134'd0;
      bus.pktin_data_valid_wr = 1'b0; bus.pktin_data_valid = 1'b0;
      bus.pktout_ready = 1'b0; bus.key_ready = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk); #1;
      n_vec++;
      if (bus.pktin_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_ready: got %b need 1", bus.pktin_ready);
      end
      n_vec++;
      if ({bus.pktout_data_wr, bus.pktout_data_valid_wr, bus.pktout_data_valid,
           bus.key_wr, bus.key_valid} !== 5'd0 || bus.pktout_data !== 134'd0) begin
         n_err++; $display("FAIL reset_strobes: got %b/%h need 0", {bus.pktout_data_wr,
            bus.pktout_data_valid_wr, bus.pktout_data_valid, bus.key_wr, bus.key_valid}, bus.pktout_data);
      end
      n_vec++;
      if (bus.key !== 512'd0 || bus.pkt_cnt !== 32'd0 || bus.err_cnt !== 16'd0) begin
         n_err++; $display("FAIL reset_regs: key %h pkt %0d err %0d need 0", bus.key, bus.pkt_cnt, bus.err_cnt);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (bus.pktin_ready !== 1'b1) begin
         n_err++; $display("FAIL post_reset_ready: got %b need 1", bus.pktin_ready);
      end
   endtask

   task automatic test_six_beat();
      int c[6];
      logic [1:0] ty;
      logic [5:0] vwr_bits, v_bits;
      logic [133:0] exp_b;
      clear_q();
      bus.key_ready = 1'b1; bus.pktout_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         ty = (i == 0) ? HD : ((i == 5) ? TL : MD);
         drive_beat(ty, 128'(i + 1), (i == 5), (i == 5), 1'b0, c[i]);
      end
      wait_outs(6, 50);
      exp_pkt = exp_pkt + 1;
      n_vec++;
      if (out_q.size() !== 6) begin
         n_err++; $display("FAIL six_count: got %0d beats need 6", out_q.size());
      end
      vwr_bits = 6'd0; v_bits = 6'd0;
      for (int i = 0; i < 6 && i < out_q.size(); i++) begin
         ty = (i == 0) ? HD : ((i == 5) ? TL : MD);
         exp_b = {ty, 4'd0, 128'(i + 1)};
         vwr_bits[i] = out_vwr_q[i];
         v_bits[i] = out_v_q[i];
         n_vec++;
         if (out_q[i] !== exp_b || out_cyc_q[i] !== c[0] + 2 + i) begin
            n_err++; $display("FAIL six_beat%0d: got %h @%0d need %h @%0d", i, out_q[i], out_cyc_q[i], exp_b, c[0] + 2 + i);
         end
      end
      n_vec++;
      if (vwr_bits !== 6'b100000 || v_bits !== 6'b100000) begin
         n_err++; $display("FAIL six_valid: got vwr %b v %b need 100000", vwr_bits, v_bits);
      end
      n_vec++;
      if (key_q.size() !== 1) begin
         n_err++; $display("FAIL six_keycount: got %0d need 1", key_q.size());
      end else if (key_q[0] !== {128'h1, 128'h2, 128'h3, 128'h4} || key_cyc_q[0] !== c[3] + 1) begin
         n_err++; $display("FAIL six_key: got %h @%0d need 1/2/3/4 @%0d", key_q[0], key_cyc_q[0], c[3] + 1);
      end
      n_vec++;
      if (bus.pkt_cnt !== 32'(exp_pkt) || bus.err_cnt !== 16'(exp_err)) begin
         n_err++; $display("FAIL six_cnt: got pkt %0d err %0d need %0d %0d", bus.pkt_cnt, bus.err_cnt, exp_pkt, exp_err);
      end
   endtask

   task automatic test_short_packet();
      int ch, ct, cm;
      clear_q();
      drive_beat(HD, 128'hA, 1'b0, 1'b0, 1'b0, ch);
      drive_beat(TL, 128'hB, 1'b1, 1'b0, 1'b0, ct);
      wait_outs(2, 50);
      exp_pkt = exp_pkt + 1;
      n_vec++;
      if (key_q.size() !== 1) begin
         n_err++; $display("FAIL short_keycount: got %0d need 1", key_q.size());
      end else if (key_q[0] !== {128'hA, 128'hB, 256'd0} || key_cyc_q[0] !== ct + 1) begin
         n_err++; $display("FAIL short_key: got %h @%0d need A/B/0/0 @%0d", key_q[0], key_cyc_q[0], ct + 1);
      end
      n_vec++;
      if (out_q.size() !== 2) begin
         n_err++; $display("FAIL short_count: got %0d need 2", out_q.size());
      end else if (out_q[1] !== {TL, 4'd0, 128'hB} || out_vwr_q[1] !== 1'b1 || out_v_q[1] !== 1'b0) begin
         n_err++; $display("FAIL short_tail: got %h vwr %b v %b need tail B vwr 1 v 0", out_q[1], out_vwr_q[1], out_v_q[1]);
      end
      // back in IDLE, a middle beat is a framing error and is not forwarded
      drive_beat(MD, 128'hC, 1'b0, 1'b0, 1'b0, cm);
      wait_outs(3, 10);
      exp_err = exp_err + 1;
      n_vec++;
      if (bus.err_cnt !== 16'(exp_err) || out_q.size() !== 2 || bus.pkt_cnt !== 32'(exp_pkt)) begin
         n_err++; $display("FAIL short_idle: got err %0d beats %0d pkt %0d need %0d 2 %0d", bus.err_cnt, out_q.size(), bus.pkt_cnt, exp_err, exp_pkt);
      end
   endtask

   task automatic test_key_stall();
      int c, ck;
      logic [511:0] exp_k;
      logic [1:0] ty;
      clear_q();
      exp_k = {128'h11, 128'h12, 128'h13, 128'h14};
      bus.key_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_beat((i == 0) ? HD : MD, 128'(8'h11 + i), 1'b0, 1'b0, 1'b0, c);
      end
      for (int i = 0; i < 10; i++) begin
         n_vec++;
         if (bus.pktin_ready !== 1'b0 || bus.key !== exp_k || bus.key_wr !== 1'b0) begin
            n_err++; $display("FAIL stall_cyc%0d: ready %b key_wr %b key %h need 0 0 %h", i, bus.pktin_ready, bus.key_wr, bus.key, exp_k);
         end
         @(posedge clk); #1;
      end
      bus.key_ready = 1'b1;
      ck = cyc;
      @(posedge clk); #1;
      drive_beat(MD, 128'h15, 1'b0, 1'b0, 1'b0, c);
      drive_beat(TL, 128'h16, 1'b1, 1'b1, 1'b0, c);
      wait_outs(6, 50);
      exp_pkt = exp_pkt + 1;
      n_vec++;
      if (key_q.size() !== 1) begin
         n_err++; $display("FAIL stall_keycount: got %0d need 1", key_q.size());
      end else if (key_q[0] !== exp_k || key_cyc_q[0] !== ck + 1) begin
         n_err++; $display("FAIL stall_key: got %h @%0d need %h @%0d", key_q[0], key_cyc_q[0], exp_k, ck + 1);
      end
      n_vec++;
      if (out_q.size() !== 6) begin
         n_err++; $display("FAIL stall_count: got %0d need 6", out_q.size());
      end
      for (int i = 0; i < 6 && i < out_q.size(); i++) begin
         ty = (i == 0) ? HD : ((i == 5) ? TL : MD);
         n_vec++;
         if (out_q[i] !== {ty, 4'd0, 128'(8'h11 + i)}) begin
            n_err++; $display("FAIL stall_beat%0d: got %h need payload %h", i, out_q[i], 8'h11 + i);
         end
      end
   endtask

   task automatic test_overflow();
      int c, bad;
      logic [1:0] ty;
      clear_q();
      bus.pktout_ready = 1'b0;
      bus.key_ready = 1'b1;
      for (int i = 0; i < 259; i++) begin
         ty = (i == 0) ? HD : ((i == 258) ? TL : MD);
         drive_beat(ty, 128'(i), (i == 258), 1'b1, 1'b1, c);
         if (i == 246 || i == 247 || i == 255) begin
            n_vec++;
            if (bus.pktin_ready !== ((i == 246) ? 1'b1 : 1'b0)) begin
               n_err++; $display("FAIL af_ready_%0d: got %b need %b", i + 1, bus.pktin_ready, (i == 246));
            end
         end
      end
      exp_err = exp_err + 3;
      exp_pkt = exp_pkt + 1;
      n_vec++;
      if (bus.err_cnt !== 16'(exp_err) || bus.pkt_cnt !== 32'(exp_pkt)) begin
         n_err++; $display("FAIL ovf_cnt: got err %0d pkt %0d need %0d %0d", bus.err_cnt, bus.pkt_cnt, exp_err, exp_pkt);
      end
      n_vec++;
      if (out_q.size() !== 0) begin
         n_err++; $display("FAIL ovf_held: got %0d beats out need 0", out_q.size());
      end
      bus.pktout_ready = 1'b1;
      wait_outs(256, 400);
      n_vec++;
      if (out_q.size() !== 256) begin
         n_err++; $display("FAIL ovf_drain_count: got %0d need 256", out_q.size());
      end
      bad = -1;
      for (int i = 0; i < out_q.size(); i++) begin
         ty = (i == 0) ? HD : MD;
         if (bad < 0 && out_q[i] !== {ty, 4'd0, 128'(i)}) bad = i;
      end
      n_vec++;
      if (bad >= 0) begin
         n_err++; $display("FAIL ovf_drain_order: beat %0d got %h need payload %0d", bad, out_q[bad], bad);
      end
      n_vec++;
      if (key_q.size() !== 1 || (key_q.size() == 1 && key_q[0] !== {128'd0, 128'd1, 128'd2, 128'd3})) begin
         n_err++; $display("FAIL ovf_key: got %0d keys, need one key 0/1/2/3", key_q.size());
      end
   endtask

   task automatic test_framing_errors();
      int c;
      clear_q();
      drive_beat(MD, 128'h21, 1'b0, 1'b0, 1'b0, c);
      drive_beat(HD, 128'h22, 1'b0, 1'b0, 1'b0, c);
      drive_beat(HD, 128'h23, 1'b0, 1'b0, 1'b0, c);
      drive_beat(TL, 128'h24, 1'b1, 1'b1, 1'b0, c);
      wait_outs(3, 50);
      exp_err = exp_err + 2;
      exp_pkt = exp_pkt + 1;
      n_vec++;
      if (bus.err_cnt !== 16'(exp_err) || bus.pkt_cnt !== 32'(exp_pkt)) begin
         n_err++; $display("FAIL frm_cnt: got err %0d pkt %0d need %0d %0d", bus.err_cnt, bus.pkt_cnt, exp_err, exp_pkt);
      end
      n_vec++;
      if (key_q.size() !== 2) begin
         n_err++; $display("FAIL frm_keycount: got %0d need 2", key_q.size());
      end else if (key_q[0] !== {128'h22, 384'd0} || key_q[1] !== {128'h23, 128'h24, 256'd0}) begin
         n_err++; $display("FAIL frm_keys: got %h then %h need 22/0/0/0 then 23/24/0/0", key_q[0], key_q[1]);
      end
      n_vec++;
      if (out_q.size() !== 3) begin
         n_err++; $display("FAIL frm_count: got %0d need 3", out_q.size());
      end else if (out_q[0] !== {HD, 4'd0, 128'h22} || out_q[1] !== {HD, 4'd0, 128'h23} ||
                   out_q[2] !== {TL, 4'd0, 128'h24}) begin
         n_err++; $display("FAIL frm_beats: got %h %h %h need 22 23 24", out_q[0], out_q[1], out_q[2]);
      end
   endtask

   task automatic test_reset_mid_packet();
      int c;
      clear_q();
      bus.pktout_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive_beat((i == 0) ? HD : MD, 128'(8'h31 + i), 1'b0, 1'b0, 1'b0, c);
      end
      #3 rst_n = 1'b0;
      #1;
      n_vec++;
      if (bus.pktin_ready !== 1'b1 || bus.pktout_data_wr !== 1'b0 || bus.key_wr !== 1'b0 ||
          bus.key !== 512'd0 || bus.pktout_data !== 134'd0) begin
         n_err++; $display("FAIL rst_mid_out: ready %b wr %b key_wr %b key %h need 1 0 0 0", bus.pktin_ready, bus.pktout_data_wr, bus.key_wr, bus.key);
      end
      n_vec++;
      if (bus.pkt_cnt !== 32'd0 || bus.err_cnt !== 16'd0) begin
         n_err++; $display("FAIL rst_mid_cnt: got pkt %0d err %0d need 0 0", bus.pkt_cnt, bus.err_cnt);
      end
      exp_pkt = 0; exp_err = 0;
      bus.pktout_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      clear_q();
      drive_beat(HD, 128'h41, 1'b0, 1'b0, 1'b0, c);
      drive_beat(TL, 128'h42, 1'b1, 1'b1, 1'b0, c);
      wait_outs(2, 50);
      exp_pkt = 1;
      n_vec++;
      if (out_q.size() !== 2) begin
         n_err++; $display("FAIL rst_fresh_count: got %0d need 2", out_q.size());
      end else if (out_q[0] !== {HD, 4'd0, 128'h41} || out_q[1] !== {TL, 4'd0, 128'h42}) begin
         n_err++; $display("FAIL rst_fresh_beats: got %h %h need 41 42", out_q[0], out_q[1]);
      end
      n_vec++;
      if (key_q.size() !== 1 || (key_q.size() == 1 && key_q[0] !== {128'h41, 128'h42, 256'd0})) begin
         n_err++; $display("FAIL rst_fresh_key: got %0d keys need one key 41/42/0/0", key_q.size());
      end
      n_vec++;
      if (bus.pkt_cnt !== 32'(exp_pkt) || bus.err_cnt !== 16'(exp_err)) begin
         n_err++; $display("FAIL rst_fresh_cnt: got pkt %0d err %0d need %0d %0d", bus.pkt_cnt, bus.err_cnt, exp_pkt, exp_err);
      end
   endtask

   initial begin
      test_reset();
      test_six_beat();
      test_short_packet();
      test_key_stall();
      test_overflow();
      test_framing_errors();
      test_reset_mid_packet();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
